// File: rtl/dht11_pkg.sv
// dht11_pkg: shared types and frame constants for the single-wire sensor reader.
package dht11_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START_LOW,
    ST_WAIT_RESP,
    ST_ACK_LOW,
    ST_ACK_HIGH,
    ST_BIT_LOW,
    ST_BIT_HIGH,
    ST_CHECK
  } state_e;

  localparam int FRAME_BITS    = 40;
  localparam int BYTE_HUM_INT  = 0;
  localparam int BYTE_HUM_DEC  = 1;
  localparam int BYTE_TMP_INT  = 2;
  localparam int BYTE_TMP_DEC  = 3;
  localparam int BYTE_CHECKSUM = 4;

  // Byte 0 arrives first, so it sits in the most significant byte of the frame.
  function automatic logic [7:0] frame_byte(input logic [FRAME_BITS-1:0] frame, input int idx);
    return 8'(frame >> (8 * (4 - idx)));
  endfunction

endpackage

// File: rtl/dht11_reader_if.sv
// dht11_reader_if: host-side handshake, sensor pad and result bus of the reader.
interface dht11_reader_if;
  logic       start;
  logic       dht_in;
  logic       dht_oe;
  logic       busy;
  logic       valid;
  logic       crc_err;
  logic       timeout_err;
  logic [7:0] hum_int;
  logic [7:0] hum_dec;
  logic [7:0] tmp_int;
  logic [7:0] tmp_dec;
  logic       th;
  logic       tl;

  modport master (
    output start, dht_in,
    input  dht_oe, busy, valid, crc_err, timeout_err,
    input  hum_int, hum_dec, tmp_int, tmp_dec, th, tl
  );

  modport slave (
    input  start, dht_in,
    output dht_oe, busy, valid, crc_err, timeout_err,
    output hum_int, hum_dec, tmp_int, tmp_dec, th, tl
  );
endinterface

// File: rtl/dht11_sync.sv
// dht11_sync: 2-FF synchroniser for the sensor pad with rise/fall pulses.
module dht11_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);
  logic r_meta, r_sync, r_prev;

  // The idle line is pulled up, so reset to 1 to avoid a false edge on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;
endmodule

// File: rtl/dht11_reader.sv
// dht11_reader: issues the host start pulse, decodes the 40-bit response by
// pulse width, verifies the checksum and keeps hysteresis temperature flags.
import dht11_pkg::*;

module dht11_reader #(
  parameter int START_LOW_CYC  = 18000,
  parameter int BIT_THRESH_CYC = 50,
  parameter int TIMEOUT_CYC    = 200,
  parameter int POLL_CYC       = 0,
  parameter int TEMP_HI        = 35,
  parameter int TEMP_LO        = 10,
  parameter int HYST           = 2
) (
  input logic           clk,
  input logic           rst_n,
  dht11_reader_if.slave bus
);
  localparam int CNT_MAX   = (START_LOW_CYC > TIMEOUT_CYC) ? START_LOW_CYC : TIMEOUT_CYC;
  localparam int CW        = $clog2(CNT_MAX + 1);
  localparam int BW        = $clog2(FRAME_BITS + 1);
  localparam int PW        = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;
  localparam int POLL_LAST = (POLL_CYC > 0) ? POLL_CYC - 1 : 0;

  state_e                r_state, w_next;
  logic [CW-1:0]         r_cnt;
  logic [BW-1:0]         r_bitcnt;
  logic [FRAME_BITS-1:0] r_shift;
  logic [PW-1:0]         r_poll;
  logic                  w_rise, w_fall, w_poll_tick, w_wait_to, w_cnt_done, w_bit;
  logic [7:0]            w_sum, w_tmp;
  logic                  w_th_next, w_tl_next;
  logic                  r_valid, r_crc_err, r_timeout_err, r_th, r_tl;
  logic [7:0]            r_hum_int, r_hum_dec, r_tmp_int, r_tmp_dec;

  dht11_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (bus.dht_in),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_poll_tick = (POLL_CYC != 0) && (r_poll == PW'(POLL_LAST));
  assign w_cnt_done  = (r_cnt >= CW'(TIMEOUT_CYC - 1));
  assign w_bit       = (r_cnt > CW'(BIT_THRESH_CYC));
  assign w_sum       = frame_byte(r_shift, BYTE_HUM_INT) + frame_byte(r_shift, BYTE_HUM_DEC)
                     + frame_byte(r_shift, BYTE_TMP_INT) + frame_byte(r_shift, BYTE_TMP_DEC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Any wait state that sees no edge before the shared counter expires aborts to IDLE.
  always_comb begin
    w_next    = r_state;
    w_wait_to = 1'b0;
    unique case (r_state)
      ST_IDLE:      if (bus.start || w_poll_tick) w_next = ST_START_LOW;
      ST_START_LOW: if (r_cnt == CW'(START_LOW_CYC - 1)) w_next = ST_WAIT_RESP;
      ST_WAIT_RESP: if (w_fall) w_next = ST_ACK_LOW;
      ST_ACK_LOW:   if (w_rise) w_next = ST_ACK_HIGH;
      ST_ACK_HIGH:  if (w_fall) w_next = ST_BIT_LOW;
      ST_BIT_LOW:   if (w_rise) w_next = ST_BIT_HIGH;
      ST_BIT_HIGH:  if (w_fall) w_next = (r_bitcnt == BW'(FRAME_BITS - 1)) ? ST_CHECK : ST_BIT_LOW;
      ST_CHECK:     w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
    if (w_next == r_state && w_cnt_done &&
        r_state inside {ST_WAIT_RESP, ST_ACK_LOW, ST_ACK_HIGH, ST_BIT_LOW, ST_BIT_HIGH}) begin
      w_next    = ST_IDLE;
      w_wait_to = 1'b1;
    end
  end

  always_comb begin
    bus.busy        = (r_state != ST_IDLE);
    bus.dht_oe      = (r_state == ST_START_LOW);
    bus.valid       = r_valid;
    bus.crc_err     = r_crc_err;
    bus.timeout_err = r_timeout_err;
    bus.hum_int     = r_hum_int;
    bus.hum_dec     = r_hum_dec;
    bus.tmp_int     = r_tmp_int;
    bus.tmp_dec     = r_tmp_dec;
    bus.th          = r_th;
    bus.tl          = r_tl;
  end

  always_comb begin
    w_tmp     = frame_byte(r_shift, BYTE_TMP_INT);
    w_th_next = r_th;
    w_tl_next = r_tl;
    if (w_tmp >= 8'(TEMP_HI))             w_th_next = 1'b1;
    else if (w_tmp < 8'(TEMP_HI - HYST))  w_th_next = 1'b0;
    if (w_tmp <= 8'(TEMP_LO))             w_tl_next = 1'b1;
    else if (w_tmp > 8'(TEMP_LO + HYST))  w_tl_next = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_poll <= '0;
    end else if (w_poll_tick || POLL_CYC == 0) begin
      r_poll <= '0;
    end else begin
      r_poll <= r_poll + 1'b1;
    end
  end

  // The counter restarts on every state change so it times both waits and high widths.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_bitcnt      <= '0;
      r_shift       <= '0;
      r_valid       <= 1'b0;
      r_crc_err     <= 1'b0;
      r_timeout_err <= 1'b0;
      r_hum_int     <= 8'h00;
      r_hum_dec     <= 8'h00;
      r_tmp_int     <= 8'h00;
      r_tmp_dec     <= 8'h00;
      r_th          <= 1'b0;
      r_tl          <= 1'b0;
    end else begin
      r_valid       <= 1'b0;
      r_crc_err     <= 1'b0;
      r_timeout_err <= w_wait_to;
      if (r_state == ST_IDLE || r_state != w_next) r_cnt <= '0;
      else if (r_cnt != CW'(CNT_MAX))              r_cnt <= r_cnt + 1'b1;
      if (r_state == ST_IDLE && w_next == ST_START_LOW) begin
        r_bitcnt <= '0;
        r_shift  <= '0;
      end
      if (r_state == ST_BIT_HIGH && w_fall) begin
        r_shift  <= {r_shift[FRAME_BITS-2:0], w_bit};
        r_bitcnt <= r_bitcnt + 1'b1;
      end
      if (r_state == ST_CHECK) begin
        if (w_sum == frame_byte(r_shift, BYTE_CHECKSUM)) begin
          r_valid   <= 1'b1;
          r_hum_int <= frame_byte(r_shift, BYTE_HUM_INT);
          r_hum_dec <= frame_byte(r_shift, BYTE_HUM_DEC);
          r_tmp_int <= frame_byte(r_shift, BYTE_TMP_INT);
          r_tmp_dec <= frame_byte(r_shift, BYTE_TMP_DEC);
          r_th      <= w_th_next;
          r_tl      <= w_tl_next;
        end else begin
          r_crc_err <= 1'b1;
        end
      end
    end
  end
endmodule
